// File: rtl/decode_pkg.sv
// Shared types and field layout for the decode stage: opcodes, ALU ops,
// instruction field positions, immediate widths and the control bundle.
package decode_pkg;

  localparam int unsigned INSTR_W  = 20;
  localparam int unsigned NREGS    = 16;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned ALU_W    = 3;

  localparam int unsigned OP_LSB     = 16;
  localparam int unsigned RD_LSB     = 12;
  localparam int unsigned RS1_LSB    = 8;
  localparam int unsigned RS2_LSB    = 4;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned FUNCT_W    = 4;
  localparam int unsigned SB_RS1_LSB = 12;
  localparam int unsigned SB_RS2_LSB = 8;

  localparam int unsigned IMM8_W  = 8;
  localparam int unsigned IMM16_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_RALU  = 4'd1,
    OP_ADDI  = 4'd2,
    OP_LOAD  = 4'd3,
    OP_STORE = 4'd4,
    OP_BEQ   = 4'd5,
    OP_BNE   = 4'd6,
    OP_JMP   = 4'd7
  } opcode_t;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic    ALUSrc;
    logic    RegWrite;
    logic    MemWrite;
    logic    ResultSrc;
    logic    Branch;
    logic    BranchNe;
    logic    Jump;
    alu_op_t ALUControl;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// 16-entry register file: 2 read ports, 1 write port, synchronous reset.
// Define RF_BYPASS_EN for write-first reads of the register being written.
module reg_file
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [REG_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wrLive;

  assign wrLive = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (wrLive) begin
      regs[wa] <= wd;
    end
  end

`ifdef RF_BYPASS_EN
  // Write-first: a register being written this cycle reads as the new value.
  always_comb begin
    rd1 = (rs1 == '0) ? '0 : ((wrLive && rs1 == wa) ? wd : regs[rs1]);
    rd2 = (rs2 == '0) ? '0 : ((wrLive && rs2 == wa) ? wd : regs[rs2]);
  end
`else
  always_comb begin
    rd1 = (rs1 == '0) ? '0 : regs[rs1];
    rd2 = (rs2 == '0) ? '0 : regs[rs2];
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decoder, register file, and the ID/EX register.
// Register-file write-first bypass is selected by RF_BYPASS_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]    PCD,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic               RegWriteW,
  input  logic [REG_W-1:0]   RdW,
  input  logic [DATA_W-1:0]  ResultW,
  output logic [REG_W-1:0]   Rs1D,
  output logic [REG_W-1:0]   Rs2D,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [REG_W-1:0]   Rs1E,
  output logic [REG_W-1:0]   Rs2E,
  output logic [REG_W-1:0]   RdE,
  output logic [PC_W-1:0]    PCE,
  output logic [ALU_W-1:0]   ALUControlE,
  output logic               ALUSrcE,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               ResultSrcE,
  output logic               BranchE,
  output logic               BranchNeE,
  output logic               JumpE,
  output logic               ValidE,
  output logic               IllegalE
);

  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic [DATA_W-1:0]  imm8Ext;
  logic [DATA_W-1:0]  imm16Ext;
  logic [DATA_W-1:0]  rd1D;
  logic [DATA_W-1:0]  rd2D;
  logic [DATA_W-1:0]  immD;
  logic [REG_W-1:0]   rdD;
  logic               illegalD;
  ctrl_t              ctrlD;
  ctrl_t              ctrlE;

  assign opcode   = InstrD[OP_LSB +: OP_W];
  assign funct    = InstrD[FUNCT_LSB +: FUNCT_W];
  assign imm8Ext  = {{(DATA_W-IMM8_W){InstrD[IMM8_W-1]}}, InstrD[IMM8_W-1:0]};
  assign imm16Ext = {{(DATA_W-IMM16_W){InstrD[IMM16_W-1]}}, InstrD[IMM16_W-1:0]};

  // Unused specifier fields decode to R0 so the hazard unit sees no false dependency.
  always_comb begin
    ctrlD    = '0;
    Rs1D     = '0;
    Rs2D     = '0;
    rdD      = '0;
    immD     = '0;
    illegalD = 1'b0;
    case (opcode)
      OP_NOP: illegalD = 1'b0;
      OP_RALU: begin
        if (!funct[FUNCT_W-1]) begin
          ctrlD.RegWrite   = 1'b1;
          ctrlD.ALUControl = alu_op_t'(funct[ALU_W-1:0]);
          rdD              = InstrD[RD_LSB +: REG_W];
          Rs1D             = InstrD[RS1_LSB +: REG_W];
          Rs2D             = InstrD[RS2_LSB +: REG_W];
        end else begin
          illegalD = 1'b1;
        end
      end
      OP_ADDI, OP_LOAD: begin
        ctrlD.ALUSrc    = 1'b1;
        ctrlD.RegWrite  = 1'b1;
        ctrlD.ResultSrc = (opcode == OP_LOAD);
        rdD             = InstrD[RD_LSB +: REG_W];
        Rs1D            = InstrD[RS1_LSB +: REG_W];
        immD            = imm8Ext;
      end
      OP_STORE: begin
        ctrlD.ALUSrc   = 1'b1;
        ctrlD.MemWrite = 1'b1;
        Rs1D           = InstrD[SB_RS1_LSB +: REG_W];
        Rs2D           = InstrD[SB_RS2_LSB +: REG_W];
        immD           = imm8Ext;
      end
      OP_BEQ, OP_BNE: begin
        ctrlD.Branch     = 1'b1;
        ctrlD.BranchNe   = (opcode == OP_BNE);
        ctrlD.ALUControl = ALU_SUB;
        Rs1D             = InstrD[SB_RS1_LSB +: REG_W];
        Rs2D             = InstrD[SB_RS2_LSB +: REG_W];
        immD             = imm8Ext;
      end
      OP_JMP: begin
        ctrlD.Jump = 1'b1;
        immD       = imm16Ext;
      end
      default: illegalD = 1'b1;
    endcase
  end

  reg_file #(.DATA_W(DATA_W)) u_regFile (
    .clk   (clk),
    .reset (reset),
    .rs1   (Rs1D),
    .rs2   (Rs2D),
    .rd1   (rd1D),
    .rd2   (rd2D),
    .we    (RegWriteW),
    .wa    (RdW),
    .wd    (ResultW)
  );

  // ID/EX register: reset and flush insert a bubble, stall holds.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      PCE      <= '0;
      ctrlE    <= '0;
      ValidE   <= 1'b0;
      IllegalE <= 1'b0;
    end else if (!StallE) begin
      RD1E     <= rd1D;
      RD2E     <= rd2D;
      ImmExtE  <= immD;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= rdD;
      PCE      <= PCD;
      ctrlE    <= ctrlD;
      ValidE   <= 1'b1;
      IllegalE <= illegalD;
    end
  end

  assign ALUControlE = ctrlE.ALUControl;
  assign ALUSrcE     = ctrlE.ALUSrc;
  assign RegWriteE   = ctrlE.RegWrite;
  assign MemWriteE   = ctrlE.MemWrite;
  assign ResultSrcE  = ctrlE.ResultSrc;
  assign BranchE     = ctrlE.Branch;
  assign BranchNeE   = ctrlE.BranchNe;
  assign JumpE       = ctrlE.Jump;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases plus random traffic against
// an instruction-level reference model. Honours RF_BYPASS_EN like the design.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [14:0] pc;
    logic [2:0]  alu;
    logic        aluSrc;
    logic        regWrite;
    logic        memWrite;
    logic        resultSrc;
    logic        branch;
    logic        branchNe;
    logic        jump;
    logic        valid;
    logic        illegal;
  } eVec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] InstrD = '0;
  logic [14:0] PCD = '0;
  logic        StallE = 1'b0;
  logic        FlushE = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [3:0]  RdW = '0;
  logic [31:0] ResultW = '0;
  logic [3:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [31:0] RD1E, RD2E, ImmExtE;
  logic [14:0] PCE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE, RegWriteE, MemWriteE, ResultSrcE, BranchE, BranchNeE, JumpE;
  logic        ValidE, IllegalE;

  int errors = 0;
  int checks = 0;

  logic [31:0] mregs [16];
  logic        wEn;
  logic [3:0]  wAddr;
  logic [31:0] wData;
  eVec_t       lastE;
  eVec_t       expQ [$];
  eVec_t       actE;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .StallE(StallE), .FlushE(FlushE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .PCE(PCE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE), .BranchNeE(BranchNeE),
    .JumpE(JumpE), .ValidE(ValidE), .IllegalE(IllegalE)
  );

  assign actE = '{rd1: RD1E, rd2: RD2E, imm: ImmExtE, rs1: Rs1E, rs2: Rs2E, rd: RdE, pc: PCE,
                  alu: ALUControlE, aluSrc: ALUSrcE, regWrite: RegWriteE, memWrite: MemWriteE,
                  resultSrc: ResultSrcE, branch: BranchE, branchNe: BranchNeE, jump: JumpE,
                  valid: ValidE, illegal: IllegalE};

  function automatic logic [31:0] readReg(input logic [3:0] idx);
    if (idx == 4'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (wEn && wAddr == idx) return wData;
`endif
    return mregs[idx];
  endfunction

  // Instruction-level meaning of each opcode, straight from the ISA table.
  function automatic eVec_t modelDecode(input logic [19:0] ins, input logic [14:0] pc);
    eVec_t e;
    int    op;
    int    f;
    e = '0;
    op = int'(ins[19:16]);
    f = int'(ins[3:0]);
    e.valid = 1'b1;
    e.pc = pc;
    if (op == 1) begin
      if (f < 8) begin
        e.rd = ins[15:12]; e.rs1 = ins[11:8]; e.rs2 = ins[7:4];
        e.alu = 3'(f); e.regWrite = 1'b1;
      end else e.illegal = 1'b1;
    end else if (op == 2 || op == 3) begin
      e.rd = ins[15:12]; e.rs1 = ins[11:8];
      e.imm = 32'(int'($signed(ins[7:0])));
      e.aluSrc = 1'b1; e.regWrite = 1'b1; e.resultSrc = (op == 3);
    end else if (op == 4) begin
      e.rs1 = ins[15:12]; e.rs2 = ins[11:8];
      e.imm = 32'(int'($signed(ins[7:0])));
      e.aluSrc = 1'b1; e.memWrite = 1'b1;
    end else if (op == 5 || op == 6) begin
      e.rs1 = ins[15:12]; e.rs2 = ins[11:8];
      e.imm = 32'(int'($signed(ins[7:0])));
      e.branch = 1'b1; e.branchNe = (op == 6); e.alu = 3'd1;
    end else if (op == 7) begin
      e.imm = 32'(int'($signed(ins[15:0])));
      e.jump = 1'b1;
    end else if (op != 0) begin
      e.illegal = 1'b1;
    end
    e.rd1 = readReg(e.rs1);
    e.rd2 = readReg(e.rs2);
    return e;
  endfunction

  task automatic step(input logic rst, input logic [19:0] ins, input logic [14:0] pc,
                      input logic st, input logic fl, input logic we, input logic [3:0] wa,
                      input logic [31:0] wd);
    eVec_t e;
    @(negedge clk);
    reset = rst; InstrD = ins; PCD = pc; StallE = st; FlushE = fl;
    RegWriteW = we; RdW = wa; ResultW = wd;
    wEn = we && !rst && (wa != 4'd0); wAddr = wa; wData = wd;
    #1;
    e = modelDecode(ins, pc);
    checks++;
    if ({Rs1D, Rs2D} !== {e.rs1, e.rs2}) begin
      errors++;
      $display("FAIL rsD instr=%h got=%h want=%h", ins, {Rs1D, Rs2D}, {e.rs1, e.rs2});
    end
    if (rst || fl) e = '0;
    else if (st) e = lastE;
    lastE = e;
    expQ.push_back(e);
    if (rst) begin
      for (int i = 0; i < 16; i++) mregs[i] = 32'd0;
    end else if (we && wa != 4'd0) begin
      mregs[wa] = wd;
    end
  endtask

  task automatic go(input logic [19:0] ins);
    step(1'b0, ins, 15'($urandom), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  // Monitor: after every active edge compare the ID/EX outputs with the oldest expectation.
  initial begin
    eVec_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checks++;
        if (actE !== exp) begin
          errors++;
          $display("FAIL idex got=%h want=%h", actE, exp);
        end
      end
    end
  end

  initial begin
    logic [19:0] ins;
    logic        rst, st, fl, we;
    lastE = '0;
    wEn = 1'b0; wAddr = '0; wData = '0;
    for (int i = 0; i < 16; i++) mregs[i] = 32'hDEAD_0000 + 32'(i);

    // Reset with a live instruction present, then prove every register reads zero.
    step(1'b1, 20'h1_1230, 15'h1234, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int i = 1; i < 16; i++) go({4'h1, 4'h0, 4'(i), 4'(i), 4'h0});

    // Write R2=5, then ADDI R3,R2,-1.
    step(1'b0, 20'h0_0000, 15'd4, 1'b0, 1'b0, 1'b1, 4'd2, 32'd5);
    go(20'h2_3_2_FF);
    // Write to R0 is dropped.
    step(1'b0, 20'h0_0000, 15'd8, 1'b0, 1'b0, 1'b1, 4'd0, 32'd7);
    go(20'h1_1_0_0_0);
    // Same-cycle write and read of R4.
    step(1'b0, 20'h1_5_4_4_0, 15'd12, 1'b0, 1'b0, 1'b1, 4'd4, 32'd9);
    go(20'h1_5_4_4_0);
    // Flush, stall hold, flush+stall.
    go(20'h6_1_2_FC);
    step(1'b0, 20'h6_1_2_FC, 15'd20, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    go(20'h6_1_2_FC);
    step(1'b0, 20'h4_4_2_10, 15'd24, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    step(1'b0, 20'h3_6_4_80, 15'd28, 1'b1, 1'b0, 1'b1, 4'd6, 32'd3);
    step(1'b0, 20'h5_4_2_7F, 15'd32, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    // Illegal opcode, illegal funct, negative jump.
    go(20'hA_1_2_34);
    go(20'h1_3_4_5_9);
    go(20'h7_8000);
    go(20'h7_7FFF);
    // Mid-stream reset clears loaded registers.
    step(1'b1, 20'h2_1_4_01, 15'd40, 1'b0, 1'b0, 1'b1, 4'd5, 32'd77);
    go(20'h1_1_4_6_0);

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) ins = 20'($urandom);
      else ins = {4'($urandom_range(0, 7)), 16'($urandom)};
      rst = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 1) == 0);
      step(rst, ins, 15'($urandom), st, fl, we, 4'($urandom), $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
